// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall control
// and a saturating count of inserted bubbles.
module id_ex_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [9:0]  ctrl_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  output logic [9:0]  ctrl_o,
  output logic [31:0] pc_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o,
  output logic        valid_o,
  output logic        hazard_o,
  output logic [15:0] bubble_cnt_o
);

  logic hold;
  logic bubble;

  // A load in EX whose destination (non-x0) is read by the real instruction in ID.
  assign hazard_o = valid_o & ctrl_o[4] & (rd_o != 5'd0) & valid_i &
                    ((rd_o == rs1_i) | (rd_o == rs2_i));

  // Flush outranks stall; a hazard only inserts a bubble when not stalled.
  always_comb begin
    hold   = 1'b0;
    bubble = 1'b0;
    if (flush_i)       bubble = 1'b1;
    else if (stall_i)  hold   = 1'b1;
    else if (hazard_o) bubble = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_o       <= '0;
      pc_o         <= '0;
      rs1_data_o   <= '0;
      rs2_data_o   <= '0;
      imm_o        <= '0;
      rs1_o        <= '0;
      rs2_o        <= '0;
      rd_o         <= '0;
      funct3_o     <= '0;
      funct7b5_o   <= 1'b0;
      valid_o      <= 1'b0;
      bubble_cnt_o <= '0;
    end else if (!hold) begin
      pc_o       <= pc_i;
      rs1_data_o <= rs1_data_i;
      rs2_data_o <= rs2_data_i;
      imm_o      <= imm_i;
      rs1_o      <= rs1_i;
      rs2_o      <= rs2_i;
      rd_o       <= rd_i;
      funct3_o   <= funct3_i;
      funct7b5_o <= funct7b5_i;
      ctrl_o     <= (bubble || !valid_i) ? '0 : ctrl_i;
      valid_o    <= bubble ? 1'b0 : valid_i;
      if (bubble && (bubble_cnt_o != '1))
        bubble_cnt_o <= bubble_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: a driver predicts hazard and next-state values
// from a behavioural model; independent monitors pop and compare them.
module tb_id_ex_reg;

  typedef struct packed {
    logic [9:0]  ctrl;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic        valid;
    logic [15:0] cnt;
  } st_t;

  typedef struct packed {
    logic        rst, stall, flush, valid;
    logic [9:0]  ctrl;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
  } in_t;

  logic        clk = 1'b0;
  logic        reset, stall_i, flush_i, valid_i;
  logic [9:0]  ctrl_i;
  logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_i, rs2_i, rd_i;
  logic [2:0]  funct3_i;
  logic        funct7b5_i;
  logic [9:0]  ctrl_o;
  logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [2:0]  funct3_o;
  logic        funct7b5_o, valid_o, hazard_o;
  logic [15:0] bubble_cnt_o;

  int unsigned checks = 0;
  int unsigned passed = 0;

  logic hq[$];
  st_t  sq[$];
  st_t  m;
  bit   m_known = 1'b0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .funct3_i(funct3_i),
    .funct7b5_i(funct7b5_i), .ctrl_o(ctrl_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o),
    .rs2_data_o(rs2_data_o), .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .funct3_o(funct3_o), .funct7b5_o(funct7b5_o), .valid_o(valid_o), .hazard_o(hazard_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  // Reference rules: a load sitting in EX blocks a real instruction that reads its rd.
  function automatic logic model_hazard(st_t s, in_t x);
    bit is_load  = s.valid && s.ctrl[4];
    bit uses_dst = (s.rd != 0) && (s.rd == x.rs1 || s.rd == x.rs2);
    return is_load && x.valid && uses_dst;
  endfunction

  function automatic st_t model_next(st_t s, in_t x, logic hz);
    st_t n = s;
    int  c;
    if (x.rst) return '0;
    if (!x.flush && x.stall) return s;
    n.pc = x.pc; n.rs1d = x.rs1d; n.rs2d = x.rs2d; n.imm = x.imm;
    n.rs1 = x.rs1; n.rs2 = x.rs2; n.rd = x.rd; n.f3 = x.f3; n.f7 = x.f7;
    if (x.flush || hz) begin
      n.ctrl  = 10'h000;
      n.valid = 1'b0;
      c = int'(s.cnt) + 1;
      n.cnt = (c > 65535) ? 16'hFFFF : 16'(c);
    end else begin
      n.valid = x.valid;
      n.ctrl  = x.valid ? x.ctrl : 10'h000;
    end
    return n;
  endfunction

  function automatic in_t base();
    in_t x;
    x.rst = 1'b0; x.stall = 1'b0; x.flush = 1'b0; x.valid = 1'b1;
    x.ctrl = 10'h000;
    x.pc = $urandom; x.rs1d = $urandom; x.rs2d = $urandom; x.imm = $urandom;
    x.rs1 = 5'($urandom_range(1, 31)); x.rs2 = 5'($urandom_range(1, 31));
    x.rd = 5'($urandom_range(1, 31)); x.f3 = 3'($urandom); x.f7 = 1'($urandom);
    return x;
  endfunction

  task automatic step(input in_t x);
    logic hz;
    @(negedge clk);
    reset = x.rst; stall_i = x.stall; flush_i = x.flush; valid_i = x.valid;
    ctrl_i = x.ctrl; pc_i = x.pc; rs1_data_i = x.rs1d; rs2_data_i = x.rs2d;
    imm_i = x.imm; rs1_i = x.rs1; rs2_i = x.rs2; rd_i = x.rd;
    funct3_i = x.f3; funct7b5_i = x.f7;
    #1;
    hz = m_known ? model_hazard(m, x) : 1'b0;
    if (m_known) hq.push_back(hz);
    if (x.rst || m_known) begin
      m = model_next(m, x, hz);
      m_known = 1'b1;
      sq.push_back(m);
    end
  endtask

  // Hazard is combinational: compare it mid-cycle, after the driver's inputs settle.
  initial forever begin
    logic e;
    @(negedge clk);
    #2;
    if (hq.size() > 0) begin
      e = hq.pop_front();
      checks++;
      if (hazard_o === e) passed++;
      else $display("FAIL hazard t=%0t got=%b exp=%b", $time, hazard_o, e);
    end
  end

  initial forever begin
    st_t e, a;
    @(posedge clk);
    #1;
    if (sq.size() > 0) begin
      e = sq.pop_front();
      a = {ctrl_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_o, rs2_o, rd_o,
           funct3_o, funct7b5_o, valid_o, bubble_cnt_o};
      checks++;
      if (a === e) passed++;
      else $display("FAIL regs t=%0t got ctrl=%h valid=%b cnt=%h pc=%h rd=%h all=%h exp ctrl=%h valid=%b cnt=%h pc=%h rd=%h all=%h",
                    $time, a.ctrl, a.valid, a.cnt, a.pc, a.rd, a, e.ctrl, e.valid, e.cnt, e.pc, e.rd, e);
    end
  end

  initial begin
    in_t x, ld, alu;
    x = base(); x.rst = 1'b1;
    step(x);
    step(x);

    // Load followed by a dependent ALU op: one bubble, then normal load.
    ld = base(); ld.ctrl = 10'h015; ld.rd = 5'd5;
    alu = base(); alu.ctrl = 10'h201; alu.rs1 = 5'd5;
    step(ld); step(alu); step(alu); step(base());

    // Same sequence with rd = x0: no hazard.
    ld.rd = 5'd0; alu.rs1 = 5'd0; alu.rs2 = 5'd0;
    step(ld); step(alu); step(base());

    // Flush with a valid R-type.
    x = base(); x.ctrl = 10'h201; x.flush = 1'b1;
    step(x);

    // Stall over a pending hazard, inputs changing.
    ld = base(); ld.ctrl = 10'h015; ld.rd = 5'd9;
    step(ld);
    for (int i = 0; i < 3; i++) begin
      x = base(); x.rs2 = 5'd9; x.stall = 1'b1; x.ctrl = 10'($urandom);
      step(x);
    end
    x.stall = 1'b0;
    step(x);

    // Reset during a hazard with flush asserted.
    step(ld);
    x = base(); x.rs1 = 5'd9; x.flush = 1'b1; x.rst = 1'b1;
    step(x);

    // Randomized traffic with a narrow register range to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      x = base();
      x.rs1 = 5'($urandom_range(0, 3)); x.rs2 = 5'($urandom_range(0, 3));
      x.rd = 5'($urandom_range(0, 3));
      x.ctrl = 10'($urandom);
      if ($urandom_range(0, 1) == 0) x.ctrl[4] = 1'b1;
      x.valid = ($urandom_range(0, 9) < 8);
      x.stall = ($urandom_range(0, 9) < 2);
      x.flush = ($urandom_range(0, 9) == 0);
      x.rst   = ($urandom_range(0, 99) < 2);
      step(x);
    end

    // Saturation: drive the counter from reset to FFFE, then three more flushes.
    x = base(); x.rst = 1'b1;
    step(x);
    for (int i = 0; i < 65534 + 3; i++) begin
      x = base(); x.flush = 1'b1; x.ctrl = 10'($urandom);
      step(x);
    end
    x = base(); x.stall = 1'b1;
    step(x);

    for (int i = 0; i < 20 && (sq.size() > 0 || hq.size() > 0); i++) @(posedge clk);
    #3;
    if (sq.size() > 0 || hq.size() > 0) begin
      checks++;
      $display("FAIL drain pending=%0d exp=0", sq.size() + hq.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
